// File: rtl/pipearch_common.sv
// Shared pipeline-architecture package: state and configuration types for the
// strided BRAM write engine.
package pipearch_common;

    localparam int unsigned BRAM_ADDR_W = 16;
    localparam int unsigned BRAM_LEN_W  = 16;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_WRITE,
        STATE_FINISH
    } t_write_bram_state;

    typedef struct packed {
        logic [BRAM_ADDR_W-1:0] offset;
        logic [BRAM_LEN_W-1:0]  length;
        logic [BRAM_LEN_W-1:0]  stride;
        logic [BRAM_LEN_W-1:0]  ring;
    } bram_strided_properties;

    // A zero stride would park the pointer on one slot; promote it to 1.
    function automatic logic [BRAM_LEN_W-1:0] effective_stride(
        input logic [BRAM_LEN_W-1:0] stride
    );
        return (stride == '0) ? {{(BRAM_LEN_W-1){1'b0}}, 1'b1} : stride;
    endfunction

endpackage

// File: rtl/bram_ring_pointer.sv
// Line pointer for the strided BRAM writer: advances by stride and folds back
// into [0, ring) when a ring size is configured.
module bram_ring_pointer #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [LEN_W-1:0] stride,
    input  logic [LEN_W-1:0] ring,
    output logic [LEN_W-1:0] ptr
);

    logic [LEN_W-1:0] ptr_q;
    logic [LEN_W:0]   nxt;
    logic [LEN_W-1:0] wrapped;

    assign nxt = {1'b0, ptr_q} + {1'b0, stride};
    // nxt - ring < ring whenever stride <= ring, so the low bits are exact.
    assign wrapped = nxt[LEN_W-1:0] - ring;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr_q <= '0;
        end else if (advance) begin
            if ((ring != '0) && (nxt >= {1'b0, ring})) begin
                ptr_q <= wrapped;
            end else begin
                ptr_q <= nxt[LEN_W-1:0];
            end
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/write_bram_strided.sv
// Strided/ring BRAM write engine with ready/busy handshake and done pulse.
// Optional drop/ignored-start statistics under WRITE_BRAM_STRIDED_STATS_EN.
module write_bram_strided
    import pipearch_common::*;
#(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic [ADDR_W-1:0] cfg_offset,
    input  logic [LEN_W-1:0]  cfg_length,
    input  logic [LEN_W-1:0]  cfg_stride,
    input  logic [LEN_W-1:0]  cfg_ring,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
`ifdef WRITE_BRAM_STRIDED_STATS_EN
    output logic [31:0]       drop_count,
    output logic [15:0]       ignored_starts,
`endif
    output logic [LEN_W-1:0]  lines_written
);

    if (ADDR_W != BRAM_ADDR_W || LEN_W != BRAM_LEN_W) begin : g_width_check
        $error("ADDR_W/LEN_W must match the pipearch_common property widths");
    end

    t_write_bram_state      state_q, state_d;
    bram_strided_properties cfg_q, cfg_d;
    logic [LEN_W-1:0]       lines_q, lines_d;
    logic [LEN_W-1:0]       ptr;
    logic                   ptr_clear;
    logic                   accept;
    logic                   mem_we_q, done_q;
    logic [ADDR_W-1:0]      mem_waddr_q, waddr_nxt;
    logic [DATA_W-1:0]      mem_wdata_q;

    assign accept    = (state_q == STATE_WRITE) && in_we;
    assign waddr_nxt = cfg_q.offset + ADDR_W'(ptr);

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        lines_d   = lines_q;
        ptr_clear = 1'b0;
        unique case (state_q)
            STATE_IDLE: begin
                if (op_start) begin
                    cfg_d     = '{offset: cfg_offset, length: cfg_length,
                                  stride: cfg_stride, ring: cfg_ring};
                    lines_d   = '0;
                    ptr_clear = 1'b1;
                    state_d   = (cfg_length == '0) ? STATE_FINISH : STATE_WRITE;
                end
            end
            STATE_WRITE: begin
                if (accept) begin
                    lines_d = lines_q + 1'b1;
                    if (lines_q == cfg_q.length - 1'b1) begin
                        state_d = STATE_FINISH;
                    end
                end
            end
            STATE_FINISH: state_d = STATE_IDLE;
            default:      state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            cfg_q       <= '0;
            lines_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cfg_q    <= cfg_d;
            lines_q  <= lines_d;
            mem_we_q <= accept;
            // done trails the final mem_we by one cycle
            done_q   <= (state_q == STATE_FINISH);
            if (accept) begin
                mem_waddr_q <= waddr_nxt;
                mem_wdata_q <= in_wdata;
            end
        end
    end

    bram_ring_pointer #(
        .LEN_W(LEN_W)
    ) u_ptr (
        .clk    (clk),
        .reset  (reset),
        .clear  (ptr_clear),
        .advance(accept),
        .stride (effective_stride(cfg_q.stride)),
        .ring   (cfg_q.ring),
        .ptr    (ptr)
    );

    assign in_ready      = (state_q == STATE_WRITE);
    assign busy          = (state_q == STATE_WRITE);
    assign done          = done_q;
    assign mem_we        = mem_we_q;
    assign mem_waddr     = mem_waddr_q;
    assign mem_wdata     = mem_wdata_q;
    assign lines_written = lines_q;

`ifdef WRITE_BRAM_STRIDED_STATS_EN
    logic [31:0] drop_q;
    logic [15:0] ign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
            ign_q  <= '0;
        end else begin
            if (in_we && !in_ready && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
            if (op_start && (state_q != STATE_IDLE) && (ign_q != '1)) begin
                ign_q <= ign_q + 1'b1;
            end
        end
    end

    assign drop_count     = drop_q;
    assign ignored_starts = ign_q;
`endif

endmodule

// File: tb/tb_write_bram_strided.sv
// Scoreboard bench for write_bram_strided: expected writes are queued as lines
// are driven and matched against mem_we/mem_waddr/mem_wdata.
module tb_write_bram_strided;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              op_start;
    logic [ADDR_W-1:0] cfg_offset;
    logic [LEN_W-1:0]  cfg_length, cfg_stride, cfg_ring;
    logic              in_we;
    logic [DATA_W-1:0] in_wdata;
    logic              in_ready, mem_we, busy, done;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [LEN_W-1:0]  lines_written;
`ifdef WRITE_BRAM_STRIDED_STATS_EN
    logic [31:0]       drop_count;
    logic [15:0]       ignored_starts;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   drop_exp = 0;
    int   ign_exp  = 0;

    always #5 clk = ~clk;

    write_bram_strided #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .cfg_offset   (cfg_offset),
        .cfg_length   (cfg_length),
        .cfg_stride   (cfg_stride),
        .cfg_ring     (cfg_ring),
        .in_we        (in_we),
        .in_wdata     (in_wdata),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
`ifdef WRITE_BRAM_STRIDED_STATS_EN
        .drop_count   (drop_count),
        .ignored_starts(ignored_starts),
`endif
        .lines_written(lines_written)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("waddr", mem_waddr, e.addr);
                check("wdata", mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [ADDR_W-1:0] off, input logic [LEN_W-1:0] len,
                          input logic [LEN_W-1:0] str, input logic [LEN_W-1:0] rng,
                          input logic [31:0] pat, input int restart_at);
        logic [LEN_W-1:0] ptr, s;
        logic [LEN_W:0]   nxt;
        int               cnt, cyc;
        cfg_offset = off;
        cfg_length = len;
        cfg_stride = str;
        cfg_ring   = rng;
        op_start   = 1'b1;
        tick();
        op_start = 1'b0;
        s   = (str == 0) ? 1 : str;
        ptr = '0;
        cnt = 0;
        cyc = 0;
        if (len == 0) begin
            check("zl_busy", busy, 0);
            check("zl_done_early", done, 0);
            tick();
            check("zl_done", done, 1);
            check("zl_busy2", busy, 0);
            tick();
            check("zl_done_once", done, 0);
            check("zl_lines", lines_written, 0);
            return;
        end
        while (cnt < int'(len) && cyc < 100) begin
            check("in_ready", in_ready, 1);
            check("busy", busy, 1);
            in_we    = pat[cyc % 32];
            in_wdata = rand_line();
            if (in_we) begin
                sb.push_back('{addr: off + ADDR_W'(ptr), data: in_wdata});
                if (cnt == restart_at) begin
                    op_start   = 1'b1;
                    cfg_offset = 16'h0040;
                    ign_exp++;
                end
                nxt = {1'b0, ptr} + {1'b0, s};
                if (rng != 0 && nxt >= {1'b0, rng}) ptr = LEN_W'(nxt - {1'b0, rng});
                else ptr = nxt[LEN_W-1:0];
                cnt++;
            end
            tick();
            in_we    = 1'b0;
            op_start = 1'b0;
            cyc++;
        end
        if (cyc >= 100) check("timeout", cnt, len);
        check("end_done_early", done, 0);
        check("end_in_ready", in_ready, 0);
        check("end_lines", lines_written, len);
        tick();
        check("done_pulse", done, 1);
        tick();
        check("done_once", done, 0);
        check("lines_hold", lines_written, len);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        reset      = 1'b1;
        op_start   = 1'b0;
        cfg_offset = '0;
        cfg_length = '0;
        cfg_stride = '0;
        cfg_ring   = '0;
        in_we      = 1'b0;
        in_wdata   = '0;
        repeat (3) tick();
        check("rst_mem_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_lines", lines_written, 0);
        reset = 1'b0;
        tick();

        run_op(16'h0010, 4, 1, 0, 32'hffff_ffff, -1);
        run_op(16'h0100, 6, 3, 8, 32'hffff_ffff, -1);
        run_op(16'h0200, 0, 1, 0, 32'hffff_ffff, -1);

        // Line presented while idle must be dropped.
        check("idle_in_ready", in_ready, 0);
        in_we    = 1'b1;
        in_wdata = rand_line();
        drop_exp++;
        tick();
        in_we = 1'b0;
        tick();
        run_op(16'h0300, 3, 1, 0, 32'h0000_0015, -1);

        run_op(16'h0500, 5, 1, 0, 32'hffff_ffff, 1);
        // A stride of 0 behaves as 1 inside a ring.
        run_op(16'hfffe, 5, 0, 4, 32'hffff_ffff, -1);

`ifdef WRITE_BRAM_STRIDED_STATS_EN
        check("drop_count", drop_count, drop_exp);
        check("ignored_starts", ignored_starts, ign_exp);
`endif

        // Reset after two accepted lines of an eight-line op.
        cfg_offset = 16'h0000;
        cfg_length = 8;
        cfg_stride = 1;
        cfg_ring   = 0;
        op_start   = 1'b1;
        tick();
        op_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_we    = 1'b1;
            in_wdata = rand_line();
            sb.push_back('{addr: ADDR_W'(i), data: in_wdata});
            tick();
        end
        in_we = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        reset = 1'b0;
        tick();
        check("post_rst_done", done, 0);
        check("post_rst_lines", lines_written, 0);
`ifdef WRITE_BRAM_STRIDED_STATS_EN
        check("rst_drop_count", drop_count, 0);
        check("rst_ignored", ignored_starts, 0);
`endif
        run_op(16'h0020, 2, 1, 0, 32'hffff_ffff, -1);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/write_bram_strided.md
Name: write_bram_strided

Overview:
Parametrised successor to the single-burst BRAM write engine. It accepts a stream of lines from a commonwrite-style source and writes them into a BRAM port. Each line goes to a configurable base offset with a programmable stride, and the pointer can optionally wrap inside a ring region. The block adds a ready/busy handshake, a done pulse and a written-line count, and sits between a compute/read pipeline stage and a local fifobram.

Parameters:
DATA_W, 512, line width in bits
ADDR_W, 16, BRAM address width
LEN_W, 16, width of length/stride/ring fields and counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_start  in  1  latch configuration and start an operation (sampled only in IDLE)
cfg_offset  in  ADDR_W  base address
cfg_length  in  LEN_W  number of lines to write
cfg_stride  in  LEN_W  pointer increment per line; 0 treated as 1
cfg_ring  in  LEN_W  ring size in lines; 0 means no wrap
in_we  in  1  input line valid
in_wdata  in  DATA_W  input line
in_ready  out  1  high while the block can accept a line (state WRITE)
mem_we  out  1  BRAM write enable
mem_waddr  out  ADDR_W  BRAM write address
mem_wdata  out  DATA_W  BRAM write data
busy  out  1  operation in progress
done  out  1  one-cycle pulse at operation end
lines_written  out  LEN_W  lines written in the current/last operation

Behaviour:
- Reset values: mem_we=0, done=0, busy=0, in_ready=0, lines_written=0, state=IDLE. mem_waddr and mem_wdata are don't-care but are reset to 0.
- States:
  - IDLE: op_start latches all cfg_* fields, clears the pointer (ptr=0) and lines_written, then:
    - if cfg_length==0, go to FINISH;
    - otherwise go to WRITE.
  - WRITE: busy=1, in_ready=1. A line is accepted on in_we&&in_ready.
  - FINISH: done=1 for one cycle, then go to IDLE.
- Accept (registered, 1-cycle latency, so mem_we follows the accepted in_we by one cycle):
  - mem_we=1;
  - mem_waddr=(offset+ptr) mod 2^ADDR_W;
  - mem_wdata=in_wdata;
  - lines_written+1.
- Pointer update: nxt=ptr+stride, computed LEN_W+1 bits wide.
  - If ring!=0 and nxt>=ring, then ptr=nxt-ring; otherwise ptr=nxt truncated to LEN_W.
  - The block requires stride<=ring when ring!=0.
- Last line: the accept with lines_written==length-1 moves the state to FINISH. done is asserted in the cycle after the last mem_we.
- in_we outside WRITE is dropped: no write and no counter change.
- mem_we is low in every cycle without an accept.
- op_start while busy or in FINISH is ignored; the configuration is not re-latched.
- Reset mid-operation returns to IDLE next cycle. A pending mem_we is cleared and no done is generated.
- lines_written holds its value after done until the next op_start.

Optional Feature:
WRITE_BRAM_STRIDED_STATS_EN
- Defined:
  - adds output drop_count[31:0], which counts in_we cycles with in_ready=0;
  - adds output ignored_starts[15:0], which counts op_start cycles while not IDLE.
  - Both counters saturate, clear only on reset, and reset to 0.
- Undefined: these ports and their logic are absent, and there is no other behavioural change.

Decomposition:
- Shared package pipearch_common, extended with:
  - typedef t_write_bram_state {STATE_IDLE, STATE_WRITE, STATE_FINISH};
  - struct bram_strided_properties {offset, length, stride, ring}.
- One natural sub-module, bram_ring_pointer: holds ptr, applies stride with wrap, and exposes clear/advance inputs and a ptr output.

Test Plan:
- Plain burst: offset=0x10, length=4, stride=1, ring=0, in_we held high → writes to 0x10,0x11,0x12,0x13, lines_written=4, done 1 cycle after the last write.
- Strided wrap: offset=0x100, length=6, stride=3, ring=8 → addresses 0x100,0x103,0x106,0x101,0x104,0x107.
- Zero length: op_start with length=0 → no mem_we, busy stays low, done pulses exactly once 1 cycle after start.
- Gaps/idle input: length=3 with in_we toggling 1,0,1,0,1, plus in_we before op_start → exactly 3 writes in order; the pre-start line is dropped (drop_count=1 with STATS_EN).
- Restart attempt: op_start at the 2nd accepted line of a length-5 op with new offset=0x40 → ignored, original addresses continue, ignored_starts=1 with STATS_EN.
- Reset mid-op: assert reset after 2 of 8 writes → mem_we=0, busy=0, no done; the next op_start with offset=0x20 writes from 0x20.
